fc_layer3: RTL and testbench

Fully connected classifier stage directly downstream of the second convolution/max-pool stage of the LeNet datapath. It consumes that stage's serial stream of pooled, truncated activations: CO=12 channels × 4×4 = 192 words, channel-major. It multiplies each activation against NO weight columns in parallel, accumulates with bias, then emits NO saturated scores serially plus the argmax class index.

---
 rtl/fc_layer3_pkg.sv | 28 ++
 rtl/fc_layer3_if.sv | 47 ++++
 rtl/fc_layer3_mac_lane.sv | 50 +++++
 rtl/fc_layer3.sv | 183 ++++++++++++++++++
 tb/tb_fc_layer3.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer3_pkg.sv
// fc_layer3_pkg: shared definitions for the fully connected classifier stage.
//   - default sizing of the LeNet FC layer (192 inputs, 10 classes)
//   - FSM state type, also exported on the debug port of the interface
//   - helper locating one weight inside the flattened weight bus
package fc_layer3_pkg;

  localparam int NI_DEF     = 192;
  localparam int NO_DEF     = 10;
  localparam int I_BW_DEF   = 16;
  localparam int W_BW_DEF   = 8;
  localparam int B_BW_DEF   = 16;
  localparam int ACC_BW_DEF = 32;
  localparam int O_BW_DEF   = 16;
  localparam int SHIFT_DEF  = 8;
  localparam int IDX_BW     = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    DONE  = 2'd2
  } fc_state_t;

  // Bit offset of weight w[n][j] in the flattened bus (neuron-major).
  function automatic int weight_base(input int n, input int j, input int ni, input int w_bw);
    return (n * ni + j) * w_bw;
  endfunction

endpackage

// File: rtl/fc_layer3_if.sv
// fc_layer3_if: activation stream from conv stage 2 and the score stream out.
//
// Handshake: valid-only, no backpressure. A word on i_fmap is transferred on
// every rising clk edge where i_valid is high; the consumer never stalls the
// producer. On the output side o_fc_valid qualifies o_fc_result/o_fc_idx for
// exactly the cycle it is high; the receiver must take it then.
//
// Signals:
//   i_fmap       signed activation
//   i_valid      i_fmap valid this cycle
//   i_ch_end     end of one conv-2 output channel
//   i_allch_end  conv stage 2 finished all channels
//   o_fc_result  saturated score of neuron o_fc_idx
//   o_fc_valid   o_fc_result/o_fc_idx valid
//   o_fc_idx     neuron index
//   o_class      argmax index, held after o_fc_done
//   o_fc_done    one-cycle pulse, inference complete
//   o_err        sticky protocol error
//   dbg_state    current FSM state (debug)
interface fc_layer3_if
  import fc_layer3_pkg::*;
#(
  parameter int I_BW = I_BW_DEF,
  parameter int O_BW = O_BW_DEF
);
  logic signed [I_BW-1:0]   i_fmap;
  logic                     i_valid;
  logic                     i_ch_end;
  logic                     i_allch_end;
  logic signed [O_BW-1:0]   o_fc_result;
  logic                     o_fc_valid;
  logic [IDX_BW-1:0]        o_fc_idx;
  logic [IDX_BW-1:0]        o_class;
  logic                     o_fc_done;
  logic                     o_err;
  fc_state_t                dbg_state;

  modport slave (
    input  i_fmap, i_valid, i_ch_end, i_allch_end,
    output o_fc_result, o_fc_valid, o_fc_idx, o_class, o_fc_done, o_err, dbg_state
  );

  modport master (
    output i_fmap, i_valid, i_ch_end, i_allch_end,
    input  o_fc_result, o_fc_valid, o_fc_idx, o_class, o_fc_done, o_err, dbg_state
  );
endinterface

// File: rtl/fc_layer3_mac_lane.sv
// fc_layer3_mac_lane: one output neuron's multiply-accumulate lane.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of the product sum
//   acc_en       add fmap*weight this cycle
//   fmap         signed activation
//   weight       signed weight for this neuron and the current input
//   bias         signed bias for this neuron
//   sum          bias + all accumulated products (wrapping, ACC_BW wide)
// The register holds only the product sum; the bias is folded in on the
// output, which gives the bias-loaded value without needing a non-constant
// asynchronous reset value.
module fc_layer3_mac_lane #(
  parameter int I_BW   = 16,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int ACC_BW = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [I_BW-1:0]   fmap,
  input  logic signed [W_BW-1:0]   weight,
  input  logic signed [B_BW-1:0]   bias,
  output logic signed [ACC_BW-1:0] sum
);
  localparam int P_BW = I_BW + W_BW;

  logic signed [P_BW-1:0]   prod;
  logic signed [ACC_BW-1:0] prod_ext;
  logic signed [ACC_BW-1:0] bias_ext;
  logic signed [ACC_BW-1:0] acc_q;

  assign prod     = fmap * weight;
  assign prod_ext = {{(ACC_BW-P_BW){prod[P_BW-1]}}, prod};
  assign bias_ext = {{(ACC_BW-B_BW){bias[B_BW-1]}}, bias};
  assign sum      = acc_q + bias_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_q + prod_ext;
    end
  end

endmodule

// File: rtl/fc_layer3.sv
// fc_layer3: fully connected classifier after conv/pool stage 2.
// Accumulates NI activations against NO weight columns in parallel, then
// emits NO saturated scores serially followed by the argmax class.
// Ports:
//   clk           rising-edge clock
//   global_rst_n  asynchronous active-low reset
//   user_reset    synchronous clear (highest priority after global_rst_n)
//   i_weight      w[n][j] at bits [(n*NI+j)*W_BW +: W_BW]
//   i_bias        b[n] at bits [n*B_BW +: B_BW]
//   bus           activation stream in / score stream out (slave side)
module fc_layer3
  import fc_layer3_pkg::*;
#(
  parameter int NI     = NI_DEF,
  parameter int NO     = NO_DEF,
  parameter int I_BW   = I_BW_DEF,
  parameter int W_BW   = W_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int ACC_BW = ACC_BW_DEF,
  parameter int O_BW   = O_BW_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     global_rst_n,
  input  logic                     user_reset,
  input  logic [NI*NO*W_BW-1:0]    i_weight,
  input  logic [NO*B_BW-1:0]       i_bias,
  fc_layer3_if.slave               bus
);
  localparam int JW = $clog2(NI + 1);

  fc_state_t state_q, state_d;

  logic [JW-1:0]            j_q;
  logic [JW-1:0]            ch_q;
  logic [IDX_BW-1:0]        e_q;
  logic                     accept;
  logic                     allch_bad;
  int                       j_idx;

  logic signed [ACC_BW-1:0] lane_sum [NO];
  logic signed [ACC_BW-1:0] sel_sum;
  logic signed [ACC_BW-1:0] shifted;
  logic signed [O_BW-1:0]   score;

  logic signed [O_BW-1:0]   result_q;
  logic                     valid_q;
  logic [IDX_BW-1:0]        idx_q;
  logic [IDX_BW-1:0]        class_q;
  logic                     done_q;
  logic                     done_seen_q;
  logic                     err_q;
  logic signed [O_BW-1:0]   best_val_q;
  logic [IDX_BW-1:0]        best_idx_q;

  assign accept = (state_q == ACCUM) && bus.i_valid;
  // j only reaches NI outside ACCUM, where the lanes ignore the weight.
  assign j_idx  = (int'(j_q) < NI) ? int'(j_q) : 0;

  // Checked against the counts including this cycle's word/channel end, so
  // i_allch_end may coincide with the final word or follow it.
  assign allch_bad = bus.i_allch_end &&
                     (((j_q + JW'(accept)) != JW'(NI)) ||
                      ((ch_q + JW'(bus.i_ch_end)) != JW'(NI / 16)));

  for (genvar n = 0; n < NO; n++) begin : g_lane
    fc_layer3_mac_lane #(
      .I_BW   (I_BW),
      .W_BW   (W_BW),
      .B_BW   (B_BW),
      .ACC_BW (ACC_BW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (global_rst_n),
      .clear  (user_reset),
      .acc_en (accept),
      .fmap   (bus.i_fmap),
      .weight (i_weight[weight_base(n, j_idx, NI, W_BW) +: W_BW]),
      .bias   (i_bias[n*B_BW +: B_BW]),
      .sum    (lane_sum[n])
    );
  end

  // Score of neuron e: arithmetic shift, then clamp to the O_BW range.
  // The value fits when all bits from O_BW-1 upward agree with the sign.
  always_comb begin
    sel_sum = '0;
    for (int n = 0; n < NO; n++) begin
      if (e_q == IDX_BW'(n)) sel_sum = lane_sum[n];
    end
    shifted = sel_sum >>> SHIFT;
    if ((&shifted[ACC_BW-1:O_BW-1]) || !(|shifted[ACC_BW-1:O_BW-1])) begin
      score = shifted[O_BW-1:0];
    end else if (shifted[ACC_BW-1]) begin
      score = {1'b1, {(O_BW-1){1'b0}}};
    end else begin
      score = {1'b0, {(O_BW-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && (j_q == JW'(NI - 1))) state_d = EMIT;
      EMIT:    if (e_q == IDX_BW'(NO - 1)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= ACCUM;
    end else if (user_reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      j_q         <= '0;
      ch_q        <= '0;
      e_q         <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      class_q     <= '0;
      done_q      <= 1'b0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
    end else if (user_reset) begin
      j_q         <= '0;
      ch_q        <= '0;
      e_q         <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      class_q     <= '0;
      done_q      <= 1'b0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (accept) j_q <= j_q + 1'b1;
      if (bus.i_ch_end) ch_q <= ch_q + 1'b1;
      if ((bus.i_valid && (state_q != ACCUM)) || allch_bad) err_q <= 1'b1;

      if (state_q == EMIT) begin
        result_q <= score;
        idx_q    <= e_q;
        valid_q  <= 1'b1;
        e_q      <= e_q + 1'b1;
        // Strict compare: on ties the earlier (lower) index is kept.
        if ((e_q == '0) || (score > best_val_q)) begin
          best_val_q <= score;
          best_idx_q <= e_q;
        end
      end

      if ((state_q == DONE) && !done_seen_q) begin
        done_q      <= 1'b1;
        done_seen_q <= 1'b1;
        class_q     <= best_idx_q;
      end
    end
  end

  assign bus.o_fc_result = result_q;
  assign bus.o_fc_valid  = valid_q;
  assign bus.o_fc_idx    = idx_q;
  assign bus.o_class     = class_q;
  assign bus.o_fc_done   = done_q;
  assign bus.o_err       = err_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_fc_layer3.sv
// tb_fc_layer3: self-checking bench for fc_layer3 with a dot-product model.
module tb_fc_layer3;
  import fc_layer3_pkg::*;

  localparam int NI    = 192;
  localparam int NO    = 10;
  localparam int I_BW  = 16;
  localparam int W_BW  = 8;
  localparam int B_BW  = 16;
  localparam int O_BW  = 16;
  localparam int SHIFT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic global_rst_n;
  logic user_reset;
  logic [NI*NO*W_BW-1:0] i_weight;
  logic [NO*B_BW-1:0]    i_bias;

  fc_layer3_if #(.I_BW(I_BW), .O_BW(O_BW)) bus ();

  fc_layer3 dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .user_reset   (user_reset),
    .i_weight     (i_weight),
    .i_bias       (i_bias),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  int w_m [NO][NI];
  int b_m [NO];
  int a_m [NI];
  logic [IDX_BW+O_BW-1:0] exp_q [$];
  int exp_class;

  int checks = 0;
  int errors = 0;
  int first_v = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = 0;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [IDX_BW+O_BW-1:0] e;
    if (bus.o_fc_valid) begin
      if (first_v < 0) first_v = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got idx=%0d result=%0d expected no output", bus.o_fc_idx, bus.o_fc_result);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_fc_idx, bus.o_fc_result} !== e) begin
          errors++;
          $display("FAIL sb_score got idx=%0d result=%0d expected idx=%0d result=%0d",
                   bus.o_fc_idx, bus.o_fc_result, e[IDX_BW+O_BW-1:O_BW], $signed(e[O_BW-1:0]));
        end
      end
    end
    if (bus.o_fc_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  // score[n] = clamp(floor((b[n] + sum_j a[j]*w[n][j]) / 2^SHIFT)); argmax keeps first max.
  task automatic build_expected();
    longint acc;
    longint sh;
    int sc [NO];
    int best;
    logic [IDX_BW-1:0] nn;
    logic [O_BW-1:0] sv;
    exp_q.delete();
    for (int n = 0; n < NO; n++) begin
      acc = b_m[n];
      for (int j = 0; j < NI; j++) acc += longint'(a_m[j]) * longint'(w_m[n][j]);
      sh = acc >>> SHIFT;
      if (sh > 32767) sc[n] = 32767;
      else if (sh < -32768) sc[n] = -32768;
      else sc[n] = int'(sh);
      nn = IDX_BW'(n);
      sv = O_BW'(sc[n]);
      exp_q.push_back({nn, sv});
    end
    best = 0;
    for (int n = 1; n < NO; n++) if (sc[n] > sc[best]) best = n;
    exp_class = best;
  endtask

  // ---------------- drivers ----------------
  task automatic load_params();
    int wv;
    int bv;
    for (int n = 0; n < NO; n++) begin
      bv = b_m[n];
      i_bias[n*B_BW +: B_BW] = bv[B_BW-1:0];
      for (int j = 0; j < NI; j++) begin
        wv = w_m[n][j];
        i_weight[(n*NI+j)*W_BW +: W_BW] = wv[W_BW-1:0];
      end
    end
  endtask

  task automatic set_uniform(input int act, input int wt, input int bs);
    for (int j = 0; j < NI; j++) a_m[j] = act;
    for (int n = 0; n < NO; n++) begin
      b_m[n] = bs;
      for (int j = 0; j < NI; j++) w_m[n][j] = wt;
    end
  endtask

  task automatic set_random(input int amax);
    for (int j = 0; j < NI; j++) a_m[j] = int'($urandom_range(0, 2*amax - 1)) - amax;
    for (int n = 0; n < NO; n++) begin
      b_m[n] = int'($urandom_range(0, 65535)) - 32768;
      for (int j = 0; j < NI; j++) w_m[n][j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic clear_capture();
    first_v  = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic apply_user_reset(input bit with_valid);
    bus.i_valid = with_valid;
    bus.i_fmap  = 16'sh1234;
    user_reset  = 1'b1;
    @(posedge clk); #1;
    user_reset  = 1'b0;
    bus.i_valid = 1'b0;
    exp_q.delete();
    clear_capture();
  endtask

  task automatic drive_stream(input int n, input bit gaps, input bit extra, input bit allch);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk); #1;
      end
      bus.i_fmap   = I_BW'(a_m[i]);
      bus.i_valid  = 1'b1;
      bus.i_ch_end = ((i % 16) == 15);
      @(posedge clk); #1;
      last_cyc     = cyc;
      bus.i_valid  = 1'b0;
      bus.i_ch_end = 1'b0;
    end
    if (extra) begin
      bus.i_fmap  = 16'sh7fff;
      bus.i_valid = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
    end
    if (allch) begin
      bus.i_allch_end = 1'b1;
      @(posedge clk); #1;
      bus.i_allch_end = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; (k < 40) && (done_cnt == 0); k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    global_rst_n = 1'b0;
    user_reset   = 1'b0;
    bus.i_fmap = '0; bus.i_valid = 1'b0; bus.i_ch_end = 1'b0; bus.i_allch_end = 1'b0;
    set_uniform(0, 0, 0);
    load_params();
    repeat (3) @(negedge clk);
    checks++; if (bus.o_fc_result !== 16'sd0) begin errors++; $display("FAIL rst_result got %0d expected 0", bus.o_fc_result); end
    checks++; if (bus.o_fc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", bus.o_fc_valid); end
    checks++; if (bus.o_fc_idx !== 4'd0) begin errors++; $display("FAIL rst_idx got %0d expected 0", bus.o_fc_idx); end
    checks++; if (bus.o_class !== 4'd0) begin errors++; $display("FAIL rst_class got %0d expected 0", bus.o_class); end
    checks++; if (bus.o_fc_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", bus.o_fc_done); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b expected 0", bus.o_err); end
    checks++; if (bus.dbg_state !== ACCUM) begin errors++; $display("FAIL rst_state got %0d expected %0d", bus.dbg_state, ACCUM); end
    @(posedge clk); #1;
    global_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_capture();
  endtask

  // Full clean inference with the currently loaded model; all result checks inline.
  task automatic test_inference(input string name, input bit gaps);
    load_params();
    apply_user_reset(1'b0);
    build_expected();
    drive_stream(NI, gaps, 1'b0, 1'b1);
    wait_done();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_count got %0d scores left expected 0", name, exp_q.size()); end
    checks++; if (first_v != last_cyc + 1) begin errors++; $display("FAIL %s_first_valid got cycle %0d expected %0d", name, first_v, last_cyc + 1); end
    checks++; if (done_cyc != last_cyc + NO + 1) begin errors++; $display("FAIL %s_done_latency got cycle %0d expected %0d", name, done_cyc, last_cyc + NO + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses got %0d expected 1", name, done_cnt); end
    checks++; if (int'(bus.o_class) != exp_class) begin errors++; $display("FAIL %s_class got %0d expected %0d", name, bus.o_class, exp_class); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL %s_err got %b expected 0", name, bus.o_err); end
  endtask

  task automatic test_directed();
    set_uniform(256, 1, 0);
    test_inference("all_ones", 1'b0);
    for (int j = 0; j < NI; j++) w_m[7][j] = 2;
    test_inference("w7_double", 1'b0);
    set_uniform(32767, 127, 0);
    for (int n = 5; n < NO; n++) for (int j = 0; j < NI; j++) w_m[n][j] = -128;
    test_inference("saturate", 1'b0);
    set_uniform(256, 0, 0);
    b_m[3] = 1000;
    test_inference("bias3", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      set_random(1024);
      test_inference("rand_small", r[0]);
    end
    set_random(32768);
    test_inference("rand_full", 1'b1);
  endtask

  task automatic test_user_reset_mid();
    set_random(2048);
    load_params();
    apply_user_reset(1'b0);
    drive_stream(100, 1'b0, 1'b0, 1'b0);
    apply_user_reset(1'b1);
    build_expected();
    drive_stream(NI, 1'b0, 1'b0, 1'b1);
    wait_done();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ureset_count got %0d scores left expected 0", exp_q.size()); end
    checks++; if (done_cyc != last_cyc + NO + 1) begin errors++; $display("FAIL ureset_done got cycle %0d expected %0d", done_cyc, last_cyc + NO + 1); end
    checks++; if (int'(bus.o_class) != exp_class) begin errors++; $display("FAIL ureset_class got %0d expected %0d", bus.o_class, exp_class); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL ureset_err got %b expected 0", bus.o_err); end
  endtask

  task automatic test_global_reset_mid();
    set_random(2048);
    load_params();
    apply_user_reset(1'b0);
    drive_stream(50, 1'b1, 1'b0, 1'b0);
    global_rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.dbg_state !== ACCUM) begin errors++; $display("FAIL grst_state got %0d expected %0d", bus.dbg_state, ACCUM); end
    checks++; if (bus.o_fc_valid !== 1'b0) begin errors++; $display("FAIL grst_valid got %b expected 0", bus.o_fc_valid); end
    @(posedge clk); #1;
    global_rst_n = 1'b1;
    clear_capture();
    build_expected();
    drive_stream(NI, 1'b0, 1'b0, 1'b1);
    wait_done();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL grst_count got %0d scores left expected 0", exp_q.size()); end
    checks++; if (int'(bus.o_class) != exp_class) begin errors++; $display("FAIL grst_class got %0d expected %0d", bus.o_class, exp_class); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL grst_err got %b expected 0", bus.o_err); end
  endtask

  task automatic test_overrun();
    set_random(1024);
    load_params();
    apply_user_reset(1'b0);
    build_expected();
    drive_stream(NI, 1'b0, 1'b1, 1'b1);
    wait_done();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_count got %0d scores left expected 0", exp_q.size()); end
    checks++; if (int'(bus.o_class) != exp_class) begin errors++; $display("FAIL overrun_class got %0d expected %0d", bus.o_class, exp_class); end
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b expected 1", bus.o_err); end
    apply_user_reset(1'b0);
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", bus.o_err); end
  endtask

  task automatic test_early_allch();
    set_random(1024);
    load_params();
    apply_user_reset(1'b0);
    drive_stream(NI - 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL early_pre_err got %b expected 0", bus.o_err); end
    bus.i_allch_end = 1'b1;
    @(posedge clk); #1;
    bus.i_allch_end = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL early_allch_err got %b expected 1", bus.o_err); end
    checks++; if (first_v != -1) begin errors++; $display("FAIL early_no_emit got first valid at %0d expected none", first_v); end
    checks++; if (bus.dbg_state !== ACCUM) begin errors++; $display("FAIL early_state got %0d expected %0d", bus.dbg_state, ACCUM); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_user_reset_mid();
    test_global_reset_mid();
    test_overrun();
    test_early_allch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
